vga_timing_rx: RTL and testbench
================================

Name: vga_timing_rx

Overview:
- Receive side of the VGA timing interface. Consumes hsync/vsync on vga_clk and rebuilds the pixel coordinates, data-enable and frame markers a downstream pixel sink needs.
- Checks the incoming timing against the configured 640x480@800x525 format and reports lock and errors.
- Used for loopback self-check of the projector timing path, and as the front end of capture logic.

Parameters:
- H_SYNC, 96, hsync high width in clocks
- H_BACK_PORCH, 48, clocks from end of hsync to first active pixel
- H_VALID, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, lines with vsync high per frame
- V_BACK_PORCH, 33, lines from end of vsync to first active line
- V_VALID, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive error-free frames required to lock (1..15)

Ports:
- vga_clk  in  1  pixel clock; all logic rises on it
- rst  in  1  asynchronous, active-high reset
- hsync  in  1  active-high horizontal sync, synchronous to vga_clk
- vsync  in  1  active-high vertical sync, synchronous to vga_clk
- clr_err  in  1  clears err_flag
- pix_x  out  10  active column 0..639, else 10'h3ff
- pix_y  out  10  active row 0..479, else 10'h3ff
- de  out  1  high for active pixels while locked
- frame_start  out  1  one-cycle pulse at each detected frame start
- locked  out  1  timing lock
- err  out  1  one-cycle pulse on any timing violation (outside SEARCH)
- err_flag  out  1  sticky error
- line_period  out  10  last measured clocks per line

Behaviour:
- Reset (async, rst=1): all outputs and state go to their reset values.
  - pix_x = pix_y = 10'h3ff.
  - de, frame_start, locked, err, err_flag = 0; line_period = 0.
  - FSM = SEARCH; counters = 0.
- Edge detect: hsync and vsync are registered once. hs_rise = hsync & ~hsync_d. vs_rise likewise.
- rx_h (10 bit):
  - Forced to 0 in the cycle hs_rise is seen.
  - Otherwise increments, saturating at 1023.
- vs_pending:
  - Set by vs_rise. Cleared when consumed.
  - Consumed by an hs_rise in the same or any later cycle.
- rx_v (10 bit), updated on hs_rise only:
  - If vs_pending or vs_rise: rx_v <= 0 and frame start fires.
  - Otherwise rx_v <= rx_v + 1, saturating at 1023.
- Measurements:
  - On hs_rise: line_period <= rx_h + 1 (saturated to 1023).
  - hs_width counts cycles of hsync high and is checked on hsync fall.
  - vs_lines counts hs_rise events with vsync high in the current frame.
- Violations (raise err the cycle after detection; only when FSM != SEARCH):
  - Line period is not H_TOTAL at an hs_rise.
  - hsync width is not H_SYNC.
  - At frame start, the previous frame's line count (rx_v+1) is not V_TOTAL, or vs_lines is not V_SYNC.
  - rx_h reaches 1023 (hsync timeout; fires once per saturation).
- FSM:
  - SEARCH: violations ignored. At frame start go to ACQ with good_cnt = 0 and the frame error bit cleared.
  - ACQ: any violation goes to SEARCH. At frame start with no error in the frame, good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any violation goes to SEARCH.
- locked = (FSM == LOCKED), registered.
- err_flag:
  - Set by err. Cleared by clr_err.
  - Set wins when both occur in the same cycle.
- Pixel outputs, registered with one cycle latency from the sample that carries rx_h/rx_v:
  - Active when FSM == LOCKED and rx_h is in [H_SYNC+H_BACK_PORCH, H_SYNC+H_BACK_PORCH+H_VALID-1] and rx_v is in [V_SYNC+V_BACK_PORCH, V_SYNC+V_BACK_PORCH+V_VALID-1].
  - When active: de = 1, pix_x = rx_h - 144, pix_y = rx_v - 35 (offsets shown for default parameters).
  - Otherwise: de = 0 and both coordinates = 10'h3ff.
- frame_start: registered pulse one cycle after the frame-start hs_rise, in every FSM state.
- Loss of lock: de drops in the same cycle locked falls. No partial-line output after loss.

Test Plan:
- Reset, then clean 800x525 timing (hsync high 96 clocks, vsync high lines 0-1):
  - frame_start pulses every 420000 clocks.
  - locked rises one cycle after the 3rd frame-start hs_rise.
  - err never pulses; line_period = 800.
- Locked, pixel mapping:
  - Sample rx_h=144, rx_v=35 -> next cycle pix_x=0, pix_y=0, de=1.
  - rx_h=783, rx_v=514 -> 639/479, de=1.
  - rx_h=784 -> 3ff/3ff, de=0.
- Locked, one line shortened to 799 clocks:
  - err pulses once; err_flag=1; locked and de fall together; line_period=799.
  - locked returns after 3 further clean frame starts; err_flag stays 1 until clr_err.
- Locked, hsync held low:
  - rx_h saturates at 1023; one err pulse; locked=0.
  - No further err pulses while still low.
- Wrong sync widths:
  - hsync width 95 in one line -> err.
  - Frame of 524 lines -> err at the next frame start.
  - vsync 3 lines wide -> err.
- Sticky flag and reset:
  - clr_err in the same cycle as an err pulse -> err_flag stays 1.
  - rst pulsed mid-frame while locked -> outputs immediately at reset values; relock sequence repeats as in the clean-timing scenario.

Source files
------------

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: rebuilds pixel coordinates, data-enable and frame
// markers from incoming hsync/vsync, measures the line period and checks the
// incoming timing against the configured format to produce lock and errors.
module vga_timing_rx #(
  parameter int H_SYNC       = 96,
  parameter int H_BACK_PORCH = 48,
  parameter int H_VALID      = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_SYNC       = 2,
  parameter int V_BACK_PORCH = 33,
  parameter int V_VALID      = 480,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       clr_err,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       de,
  output logic       frame_start,
  output logic       locked,
  output logic       err,
  output logic       err_flag,
  output logic [9:0] line_period
);

  localparam logic [9:0] CNT_MAX     = 10'h3ff;
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK_PORCH);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK_PORCH + H_VALID - 1);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK_PORCH);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK_PORCH + V_VALID - 1);
  localparam logic [9:0] H_TOT       = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT       = 10'(V_TOTAL);
  localparam logic [9:0] H_SYNC_W    = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W    = 10'(V_SYNC);
  localparam logic [3:0] LOCK_N      = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ACQ,
    ST_LOCKED
  } state_e;

  // Saturating 10-bit increment shared by every counter in the receiver.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // Sync history and timing counters.
  logic       hs_q, vs_q;
  logic       vs_pending_q, vs_pending_d;
  logic [9:0] rx_h_q, rx_h_d;
  logic [9:0] rx_v_q, rx_v_d;
  logic [9:0] hs_width_q, hs_width_d;
  logic [9:0] vs_lines_q, vs_lines_d;

  // Lock state machine.
  state_e     state_q, state_d;
  logic [3:0] good_q, good_d;

  // Registered outputs.
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic       de_q, pix_act;
  logic       frame_start_q;
  logic       locked_q, lock_nxt;
  logic       err_q, err_d;
  logic       err_flag_q, err_flag_d;
  logic [9:0] line_period_q, line_period_d;

  // Events and violations of the current cycle.
  logic hs_rise, hs_fall, vs_rise, frame_evt;
  logic viol_line, viol_hsw, viol_frame, viol_to, viol;
  logic h_act, v_act;

  // Edge detection, counter updates and timing checks.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    hs_rise   = hsync & ~hs_q;
    hs_fall   = ~hsync & hs_q;
    vs_rise   = vsync & ~vs_q;
    // A vsync rise waits for the next hsync rise (same cycle or later).
    frame_evt = hs_rise & (vs_pending_q | vs_rise);

    rx_h_d        = hs_rise ? 10'd0 : sat_inc(rx_h_q);
    vs_pending_d  = hs_rise ? 1'b0 : (vs_pending_q | vs_rise);
    line_period_d = hs_rise ? sat_inc(rx_h_q) : line_period_q;

    rx_v_d = rx_v_q;
    if (frame_evt)    rx_v_d = 10'd0;
    else if (hs_rise) rx_v_d = sat_inc(rx_v_q);

    hs_width_d = hs_width_q;
    if (hs_rise)    hs_width_d = 10'd1;
    else if (hsync) hs_width_d = sat_inc(hs_width_q);

    // Lines that begin with vsync high; the frame-start line opens the count.
    vs_lines_d = vs_lines_q;
    if (frame_evt)            vs_lines_d = {9'd0, vsync};
    else if (hs_rise & vsync) vs_lines_d = sat_inc(vs_lines_q);

    viol_line  = hs_rise && (sat_inc(rx_h_q) != H_TOT);
    viol_hsw   = hs_fall && (hs_width_q != H_SYNC_W);
    viol_frame = frame_evt && ((sat_inc(rx_v_q) != V_TOT) || (vs_lines_q != V_SYNC_W));
    // Fires only on the step into saturation, so a stuck hsync reports once.
    viol_to    = !hs_rise && (rx_h_q == CNT_MAX - 10'd1);
    viol       = viol_line | viol_hsw | viol_frame | viol_to;
  end

  // Lock FSM next state. A violation in ACQ drops straight back to SEARCH,
  // so reaching a frame start while still in ACQ means the frame was clean.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      ST_SEARCH: begin
        if (frame_evt) begin
          state_d = ST_ACQ;
          good_d  = 4'd0;
        end
      end
      ST_ACQ: begin
        if (viol) begin
          state_d = ST_SEARCH;
        end else if (frame_evt) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 >= LOCK_N) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (viol) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Output next values. Pixel gating uses the next lock state so that de
  // drops on the same edge as locked and no partial line escapes.
  always_comb begin
    lock_nxt   = (state_d == ST_LOCKED);
    h_act      = (rx_h_q >= H_ACT_START) && (rx_h_q <= H_ACT_END);
    v_act      = (rx_v_q >= V_ACT_START) && (rx_v_q <= V_ACT_END);
    pix_act    = lock_nxt & h_act & v_act;
    pix_x_d    = pix_act ? rx_h_q - H_ACT_START : CNT_MAX;
    pix_y_d    = pix_act ? rx_v_q - V_ACT_START : CNT_MAX;
    err_d      = viol & (state_q != ST_SEARCH);
    // Setting has priority over clearing.
    err_flag_d = err_q ? 1'b1 : (clr_err ? 1'b0 : err_flag_q);
  end

  // Sync history and timing counters.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      vs_pending_q <= 1'b0;
      rx_h_q       <= 10'd0;
      rx_v_q       <= 10'd0;
      hs_width_q   <= 10'd0;
      vs_lines_q   <= 10'd0;
    end else begin
      hs_q         <= hsync;
      vs_q         <= vsync;
      vs_pending_q <= vs_pending_d;
      rx_h_q       <= rx_h_d;
      rx_v_q       <= rx_v_d;
      hs_width_q   <= hs_width_d;
      vs_lines_q   <= vs_lines_d;
    end
  end

  // Lock FSM state and its registered lock indication.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      good_q   <= 4'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= lock_nxt;
    end
  end

  // Registered pixel, marker and error outputs.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      pix_x_q       <= CNT_MAX;
      pix_y_q       <= CNT_MAX;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
      err_flag_q    <= 1'b0;
      line_period_q <= 10'd0;
    end else begin
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      de_q          <= pix_act;
      frame_start_q <= frame_evt;
      err_q         <= err_d;
      err_flag_q    <= err_flag_d;
      line_period_q <= line_period_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign err_flag    = err_flag_q;
  assign line_period = line_period_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Self-checking bench for vga_timing_rx. Uses a scaled-down format
// (20 clocks x 12 lines) so that multi-frame lock sequences stay short;
// active window is rx_h 7..14, rx_v 4..7 (the analogue of 144..783 / 35..514).
`timescale 1ns/1ps
module tb_vga_timing_rx;

  localparam int TB_HS = 4, TB_HBP = 3, TB_HV = 8, TB_HT = 20;
  localparam int TB_VS = 2, TB_VBP = 2, TB_VV = 4, TB_VT = 12;
  localparam int TB_LOCK    = 2;
  localparam int FRAME_CLKS = TB_HT * TB_VT;

  logic       vga_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       hsync   = 1'b0;
  logic       vsync   = 1'b0;
  logic       clr_err = 1'b0;
  logic [9:0] pix_x, pix_y, line_period;
  logic       de, frame_start, locked, err, err_flag;

  vga_timing_rx #(
    .H_SYNC(TB_HS), .H_BACK_PORCH(TB_HBP), .H_VALID(TB_HV), .H_TOTAL(TB_HT),
    .V_SYNC(TB_VS), .V_BACK_PORCH(TB_VBP), .V_VALID(TB_VV), .V_TOTAL(TB_VT),
    .LOCK_FRAMES(TB_LOCK)
  ) dut (
    .vga_clk(vga_clk), .rst(rst), .hsync(hsync), .vsync(vsync), .clr_err(clr_err),
    .pix_x(pix_x), .pix_y(pix_y), .de(de), .frame_start(frame_start),
    .locked(locked), .err(err), .err_flag(err_flag), .line_period(line_period)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state, updated once per clock by tick().
  int         cyc = 0;
  int         err_cnt, err_cyc, de_cnt, lock_cyc;
  int         fs_cyc[$];
  logic [9:0] err_lp;
  logic       err_locked, err_prev_locked, err_de;
  logic       prev_locked = 1'b0;
  logic       clr_err_hold = 1'b0, clr_on_err = 1'b0, clr_at_err, flag_after_clr;
  logic       cap_en = 1'b0;
  int         cur_line = 0, cur_col = 0;
  logic [20:0] cap [TB_VT][TB_HT];

  typedef struct {
    string      name;
    int         line;
    int         col;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    err_cnt         = 0;
    err_cyc         = -1;
    de_cnt          = 0;
    lock_cyc        = -1;
    fs_cyc.delete();
    err_lp          = 10'd0;
    err_locked      = 1'b1;
    err_prev_locked = 1'b0;
    err_de          = 1'b1;
    flag_after_clr  = 1'b0;
  endtask

  // Drive one clock of sync inputs (at negedge), then sample outputs at the
  // following negedge.
  task automatic tick(input logic hs, input logic vs);
    clr_at_err = clr_on_err & err;
    clr_err    = clr_err_hold | clr_at_err;
    hsync      = hs;
    vsync      = vs;
    @(posedge vga_clk);
    @(negedge vga_clk);
    cyc++;
    if (err) begin
      err_cnt++;
      if (err_cnt == 1) begin
        err_cyc         = cyc;
        err_lp          = line_period;
        err_locked      = locked;
        err_prev_locked = prev_locked;
        err_de          = de;
      end
    end
    if (frame_start) fs_cyc.push_back(cyc);
    if (locked && !prev_locked) lock_cyc = cyc;
    if (de) de_cnt++;
    if (clr_at_err) flag_after_clr = err_flag;
    // Outputs seen now belong to the rx_h sample of the previous clock.
    if (cap_en && cur_col > 0) cap[cur_line][cur_col-1] = {de, pix_x, pix_y};
    prev_locked = locked;
  endtask

  task automatic drive_line(input int line, input int total, input int hsw, input logic vs);
    for (int c = 0; c < total; c++) begin
      cur_line = line;
      cur_col  = c;
      tick(c < hsw, vs);
    end
  endtask

  // One frame; bad_line (if >= 0) gets its own length and hsync width.
  task automatic drive_frame(input int n_lines, input int vs_w, input int bad_line,
                             input int bad_total, input int bad_hsw);
    for (int l = 0; l < n_lines; l++)
      drive_line(l, (l == bad_line) ? bad_total : TB_HT,
                 (l == bad_line) ? bad_hsw : TB_HS, l < vs_w);
  endtask

  task automatic clean_frame();
    drive_frame(TB_VT, TB_VS, -1, 0, 0);
  endtask

  // Three clean frames from SEARCH: lock must rise with the third frame start.
  task automatic lock_seq(input string tag);
    int fs1, fs2;
    clear_mon();
    clean_frame();
    clean_frame();
    check({tag, " unlocked after 2 frames"}, locked, 1'b0);
    clean_frame();
    fs1 = (fs_cyc.size() > 1) ? fs_cyc[1] : -1000000;
    fs2 = (fs_cyc.size() > 2) ? fs_cyc[2] : -1;
    check({tag, " frame_start count"}, fs_cyc.size(), 3);
    check({tag, " lock with 3rd frame start"}, lock_cyc, fs2);
    check({tag, " frame_start period"}, fs2 - fs1, FRAME_CLKS);
    check({tag, " no err"}, err_cnt, 0);
    check({tag, " line_period"}, line_period, TB_HT);
    check({tag, " locked"}, locked, 1'b1);
  endtask

  initial begin
    int t0, fs_b;

    // Pixel mapping vectors: {name, rx_v, rx_h, de, pix_x, pix_y}.
    vecs[0] = '{"first pixel",       4,  7, 1'b1, 10'd0,   10'd0};
    vecs[1] = '{"last pixel",        7, 14, 1'b1, 10'd7,   10'd3};
    vecs[2] = '{"past last col",     7, 15, 1'b0, 10'h3ff, 10'h3ff};
    vecs[3] = '{"before first col",  4,  6, 1'b0, 10'h3ff, 10'h3ff};
    vecs[4] = '{"row above window",  3,  7, 1'b0, 10'h3ff, 10'h3ff};
    vecs[5] = '{"row below window",  8, 14, 1'b0, 10'h3ff, 10'h3ff};
    vecs[6] = '{"mid pixel",         5, 10, 1'b1, 10'd3,   10'd1};
    vecs[7] = '{"row 2 last col",    6, 14, 1'b1, 10'd7,   10'd2};
    vecs[8] = '{"sync area",         0,  0, 1'b0, 10'h3ff, 10'h3ff};
    vecs[9] = '{"last row first col",7,  7, 1'b1, 10'd0,   10'd3};

    // Reset values.
    repeat (3) @(negedge vga_clk);
    check("reset pix_x", pix_x, 10'h3ff);
    check("reset pix_y", pix_y, 10'h3ff);
    check("reset de", de, 1'b0);
    check("reset frame_start", frame_start, 1'b0);
    check("reset locked", locked, 1'b0);
    check("reset err", err, 1'b0);
    check("reset err_flag", err_flag, 1'b0);
    check("reset line_period", line_period, 10'd0);
    rst = 1'b0;

    // Clean timing acquires lock.
    lock_seq("clean");

    // Pixel mapping on a locked frame.
    clear_mon();
    cap_en = 1'b1;
    clean_frame();
    cap_en = 1'b0;
    for (int i = 0; i < 10; i++)
      check({"map ", vecs[i].name}, cap[vecs[i].line][vecs[i].col],
            {vecs[i].de, vecs[i].x, vecs[i].y});
    check("map frame no err", err_cnt, 0);
    check("map frame de count", de_cnt, TB_HV * TB_VV);

    // One line shortened by a clock.
    clear_mon();
    drive_frame(TB_VT, TB_VS, 5, TB_HT - 1, TB_HS);
    check("short line err pulses", err_cnt, 1);
    check("short line err_flag", err_flag, 1'b1);
    check("short line locked before err", err_prev_locked, 1'b1);
    check("short line locked at err", err_locked, 1'b0);
    check("short line de at err", err_de, 1'b0);
    check("short line line_period", err_lp, TB_HT - 1);
    check("short line de cycles (rows 4,5 only)", de_cnt, 2 * TB_HV);
    lock_seq("relock after short line");
    check("err_flag sticky after relock", err_flag, 1'b1);

    // clr_err clears the sticky flag.
    clr_err_hold = 1'b1;
    clean_frame();
    clr_err_hold = 1'b0;
    check("clr_err clears err_flag", err_flag, 1'b0);
    check("clr_err keeps lock", locked, 1'b1);

    // hsync held low: rx_h goes 19 -> 1023 in 1004 clocks, one err only.
    clear_mon();
    t0 = cyc;
    for (int k = 0; k < 1100; k++) tick(1'b0, 1'b0);
    check("hsync stuck err pulses", err_cnt, 1);
    check("hsync stuck err time", err_cyc - t0, 1023 - (TB_HT - 1));
    check("hsync stuck locked", locked, 1'b0);
    lock_seq("relock after hsync stuck");

    // hsync one clock narrow in a single line.
    clear_mon();
    drive_frame(TB_VT, TB_VS, 5, TB_HT, TB_HS - 1);
    check("narrow hsync err pulses", err_cnt, 1);
    check("narrow hsync locked", locked, 1'b0);
    lock_seq("relock after narrow hsync");

    // Frame one line short: flagged at the following frame start.
    clear_mon();
    drive_frame(TB_VT - 1, TB_VS, -1, 0, 0);
    check("short frame no early err", err_cnt, 0);
    clean_frame();
    fs_b = (fs_cyc.size() > 1) ? fs_cyc[1] : -1;
    check("short frame err pulses", err_cnt, 1);
    check("short frame err at frame start", err_cyc, fs_b);
    check("short frame locked", locked, 1'b0);
    lock_seq("relock after short frame");

    // Clear the flag, then vsync three lines wide with clr_err on the err cycle.
    clr_err_hold = 1'b1;
    clean_frame();
    clr_err_hold = 1'b0;
    check("flag clear before vsync test", err_flag, 1'b0);
    clear_mon();
    drive_frame(TB_VT, TB_VS + 1, -1, 0, 0);
    check("wide vsync no early err", err_cnt, 0);
    clr_on_err = 1'b1;
    clean_frame();
    clr_on_err = 1'b0;
    fs_b = (fs_cyc.size() > 1) ? fs_cyc[1] : -1;
    check("wide vsync err pulses", err_cnt, 1);
    check("wide vsync err at frame start", err_cyc, fs_b);
    check("set beats clear same cycle", flag_after_clr, 1'b1);
    check("err_flag held after clr pulse", err_flag, 1'b1);
    lock_seq("relock after wide vsync");

    // Reset mid-frame while locked, inside the active window.
    for (int l = 0; l < 5; l++) drive_line(l, TB_HT, TB_HS, l < TB_VS);
    for (int c = 0; c < 10; c++) begin
      cur_line = 5;
      cur_col  = c;
      tick(c < TB_HS, 1'b0);
    end
    check("pre-reset de", de, 1'b1);
    check("pre-reset err_flag", err_flag, 1'b1);
    rst = 1'b1;
    #1;
    check("async reset pix_x", pix_x, 10'h3ff);
    check("async reset pix_y", pix_y, 10'h3ff);
    check("async reset de", de, 1'b0);
    check("async reset locked", locked, 1'b0);
    check("async reset err_flag", err_flag, 1'b0);
    check("async reset line_period", line_period, 10'd0);
    check("async reset frame_start", frame_start, 1'b0);
    @(negedge vga_clk);
    repeat (3) tick(1'b0, 1'b0);
    rst = 1'b0;
    lock_seq("relock after reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
